// File: rtl/switch_input_debouncer_if.sv
// Bundles the switch inputs and the debounced outputs of switch_input_debouncer.
// Defining SWITCH_EDGE_EN adds the per-channel rise/fall strobes.
interface switch_input_debouncer_if;
    logic [2:0] sw_raw;
    logic       W;
    logic       X;
    logic       Y;
    logic       changed;
    logic       tick;
`ifdef SWITCH_EDGE_EN
    logic [2:0] rise;
    logic [2:0] fall;

    modport master (output sw_raw, input W, input X, input Y, input changed, input tick,
                    input rise, input fall);
    modport slave  (input sw_raw, output W, output X, output Y, output changed, output tick,
                    output rise, output fall);
`else
    modport master (output sw_raw, input W, input X, input Y, input changed, input tick);
    modport slave  (input sw_raw, output W, output X, output Y, output changed, output tick);
`endif
endinterface

// File: rtl/switch_input_debouncer.sv
// Synchronizes and debounces three slide switches (W, X, Y) against a prescaled tick.
// Optional macro SWITCH_EDGE_EN adds registered rise/fall strobes per channel.
module switch_input_debouncer #(
    parameter int TICK_DIV     = 24000,
    parameter int STABLE_TICKS = 10,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    switch_input_debouncer_if.slave   bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

    logic [PW-1:0]          presc_q, presc_d;
    logic                   tick_q, tick_d;
    logic [SYNC_STAGES-1:0] sync_q [3];
    logic [2:0]             sync_last;
    logic [CW-1:0]          cnt_q [3];
    logic [CW-1:0]          cnt_d [3];
    logic [2:0]             out_q, out_d;
    logic                   changed_q, changed_d;

    // tick is registered from the next count so it is high while the count sits at TICK_DIV-1
    always_comb begin
        presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        tick_d  = (presc_d == PRESC_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) sync_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++)
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.sw_raw[i]};
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) sync_last[i] = sync_q[i][SYNC_STAGES-1];
    end

    always_comb begin
        out_d = out_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_last[i] == out_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick_q) begin
                if (cnt_q[i] == CNT_LAST) begin
                    out_d[i] = sync_last[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        changed_d = |(out_d ^ out_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            out_q     <= 3'b000;
            changed_q <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            out_q     <= out_d;
            changed_q <= changed_d;
        end
    end

    assign bus.W       = out_q[2];
    assign bus.X       = out_q[1];
    assign bus.Y       = out_q[0];
    assign bus.changed = changed_q;
    assign bus.tick    = tick_q;

`ifdef SWITCH_EDGE_EN
    logic [2:0] rise_q, fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 3'b000;
            fall_q <= 3'b000;
        end else begin
            rise_q <= out_d & ~out_q;
            fall_q <= ~out_d & out_q;
        end
    end

    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
`endif
endmodule

// File: tb/tb_switch_input_debouncer.sv
// Directed plus randomized bench for switch_input_debouncer; reference model counts
// elapsed ticks arithmetically over each mismatch window.
module tb_switch_input_debouncer;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    switch_input_debouncer_if sw_if ();

    switch_input_debouncer #(.TICK_DIV(TD), .STABLE_TICKS(ST), .SYNC_STAGES(SS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sw_if)
    );

    always #5 clk = ~clk;

    // model state: edge index since reset release, raw sample per edge, debounced levels
    int         e;
    logic [2:0] raw_at [0:8191];
    logic [2:0] m_out;
    int         since [3];
    int         n_chg, n_tick, n_rise0, n_fall0, w_rise_edge, x_rise_edge, y_rise_edge;

    function automatic int ticks_upto(int n);
        if (n < 1) return 0;
        return (n + 1) / TD - ((TD == 1) ? 1 : 0);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic model_reset();
        e = 0;
        m_out = 3'b000;
        for (int i = 0; i < 3; i++) since[i] = -1;
    endtask

    task automatic cyc(input logic [2:0] sw);
        logic [2:0] s, prev, exp_rise, exp_fall;
        logic       exp_chg, exp_tick;
        sw_if.sw_raw = sw;
        @(posedge clk);
        e++;
        if (e < 8192) raw_at[e] = sw;
        s = (e - SS >= 1 && e - SS < 8192) ? raw_at[e-SS] : 3'b000;
        prev = m_out;
        for (int i = 0; i < 3; i++) begin
            if (s[i] == m_out[i]) begin
                since[i] = -1;
            end else begin
                if (since[i] < 0) since[i] = e;
                // ticks visible at edges since..e are those asserted after edges since-1..e-1
                if (ticks_upto(e - 1) - ticks_upto(since[i] - 2) == ST) begin
                    m_out[i] = s[i];
                    since[i] = -1;
                end
            end
        end
        exp_rise = m_out & ~prev;
        exp_fall = ~m_out & prev;
        exp_chg  = |(m_out ^ prev);
        exp_tick = ((e % TD) == TD - 1);
        #1;
        chk("wxy", {5'b0, sw_if.W, sw_if.X, sw_if.Y}, {5'b0, m_out});
        chk("changed", {7'b0, sw_if.changed}, {7'b0, exp_chg});
        chk("tick", {7'b0, sw_if.tick}, {7'b0, exp_tick});
`ifdef SWITCH_EDGE_EN
        chk("rise", {5'b0, sw_if.rise}, {5'b0, exp_rise});
        chk("fall", {5'b0, sw_if.fall}, {5'b0, exp_fall});
        if (sw_if.rise[0]) n_rise0++;
        if (sw_if.fall[0]) n_fall0++;
`endif
        if (sw_if.changed) n_chg++;
        if (sw_if.tick) n_tick++;
        if (sw_if.W && prev[2] == 1'b0 && w_rise_edge < 0) w_rise_edge = e;
        if (sw_if.X && !prev[1]) x_rise_edge = e;
        if (sw_if.Y && !prev[0]) y_rise_edge = e;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("async_rst", {3'b0, sw_if.W, sw_if.X, sw_if.Y, sw_if.changed, sw_if.tick}, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    logic [2:0] rv;
    int         rlen;

    initial begin
        sw_if.sw_raw = 3'b000;
        model_reset();
        w_rise_edge = -1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {3'b0, sw_if.W, sw_if.X, sw_if.Y, sw_if.changed, sw_if.tick}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // idle: no pulses, tick every 4th cycle
        n_chg = 0; n_tick = 0;
        repeat (50) cyc(3'b000);
        chk("idle_changed_cnt", 8'(n_chg), 8'd0);
        chk("idle_tick_cnt", 8'(n_tick), 8'd12);

        // W alone: sampled at edge 51, sync high after 52, third tick seen at edge 64
        n_chg = 0;
        repeat (40) cyc(3'b100);
        chk("w_rise_edge", 8'(w_rise_edge), 8'd64);
        chk("w_changed_cnt", 8'(n_chg), 8'd1);

        // X glitch shorter than the debounce window
        n_chg = 0;
        repeat (6) cyc(3'b110);
        repeat (30) cyc(3'b100);
        chk("x_glitch_changed", 8'(n_chg), 8'd0);

        // X and Y together from an all-low state
        repeat (30) cyc(3'b000);
        n_chg = 0; x_rise_edge = -1; y_rise_edge = -2;
        repeat (30) cyc(3'b011);
        chk("xy_changed_cnt", 8'(n_chg), 8'd1);
        chk("xy_same_edge", 8'(x_rise_edge == y_rise_edge), 8'd1);

        // all high, then reset while held high
        repeat (30) cyc(3'b111);
        chk("all_high", {5'b0, sw_if.W, sw_if.X, sw_if.Y}, 8'h07);
        pulse_reset();
        repeat (30) cyc(3'b111);
        chk("rerise_after_rst", {5'b0, sw_if.W, sw_if.X, sw_if.Y}, 8'h07);

`ifdef SWITCH_EDGE_EN
        repeat (30) cyc(3'b000);
        n_rise0 = 0; n_fall0 = 0;
        repeat (30) cyc(3'b001);
        repeat (30) cyc(3'b000);
        chk("rise0_cnt", 8'(n_rise0), 8'd1);
        chk("fall0_cnt", 8'(n_fall0), 8'd1);
`endif

        // randomized holds, with one reset partway through
        for (int k = 0; k < 250; k++) begin
            rv   = 3'($urandom);
            rlen = $urandom_range(1, 16);
            repeat (rlen) cyc(rv);
            if (k == 120) pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/switch_input_debouncer.md
Name: switch_input_debouncer

Overview:
- Upstream conditioning stage for the board's logic-function/seven-segment display block.
- Takes three raw, asynchronous slide-switch inputs and synchronizes each into the clock domain.
- Debounces each input against a prescaled tick and drives clean, glitch-free W, X, Y levels into the display logic.
- Also emits a one-cycle change strobe that downstream logic can use for event counting or display refresh.

Parameters:
- TICK_DIV, 24000, clock cycles per debounce tick (1 ms at 24 MHz); legal values >= 1; 1 means a tick every cycle.
- STABLE_TICKS, 10, consecutive ticks a synchronized input must differ from its debounced value before the output flips; legal values >= 1.
- SYNC_STAGES, 2, flip-flops in each input synchronizer chain; legal values >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sw_raw  input  3  raw switch levels: [2]=W, [1]=X, [0]=Y; asynchronous to clk.
- W  output  1  debounced sw_raw[2].
- X  output  1  debounced sw_raw[1].
- Y  output  1  debounced sw_raw[0].
- changed  output  1  one-cycle pulse, high in the first cycle any of W/X/Y shows a new value.
- tick  output  1  prescaler strobe, high for one cycle every TICK_DIV cycles.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-count):
  - All synchronizer flops, the prescaler, per-channel counters, W/X/Y, changed and tick clear to 0.
  - Operation resumes on the first rising edge after rst_n is deasserted.
- Prescaler:
  - Free-running counter, 0..TICK_DIV-1, wraps to 0.
  - tick=1 in the cycle the count equals TICK_DIV-1.
  - With TICK_DIV=1, tick is high every cycle after reset.
- Synchronizer:
  - Each sw_raw bit passes through SYNC_STAGES flops.
  - The last stage (sync[i]) is the only value the debounce logic sees.
- Per-channel debounce (identical and independent for i=0..2):
  - Counter width is clog2(STABLE_TICKS+1).
  - If sync[i]==out[i]: counter clears to 0 that cycle, whether or not tick is high.
  - If sync[i]!=out[i] and tick=1 and counter<STABLE_TICKS-1: counter increments.
  - If sync[i]!=out[i] and tick=1 and counter==STABLE_TICKS-1: out[i] takes sync[i] on that edge and the counter clears.
  - If sync[i]!=out[i] and tick=0: counter holds.
  - A mismatch interrupted by even one cycle of agreement restarts the count from 0.
  - Latency from the sync[i] change to the out[i] update is between (STABLE_TICKS-1)*TICK_DIV+1 and STABLE_TICKS*TICK_DIV cycles, plus SYNC_STAGES cycles from sw_raw.
- changed:
  - Registered; high for exactly one cycle, coincident with the first cycle the new W/X/Y value is visible.
  - Several channels flipping on the same edge produce a single pulse.
  - A channel flipping on the next tick produces a separate pulse.
- The counter never exceeds STABLE_TICKS-1, so there is no wrap hazard.
- Outputs are glitch-free; all are driven directly from flops.

Optional Feature:
- Macro: SWITCH_EDGE_EN.
- When defined:
  - Adds outputs rise[2:0] and fall[2:0].
  - rise[i] pulses high for one cycle when out[i] goes 0->1; fall[i] pulses when out[i] goes 1->0.
  - Both are aligned with changed and cleared by reset.
  - changed equals the OR of all rise and fall bits.
- When undefined:
  - The ports and their logic are absent.
  - All other behaviour is identical.

Test Plan:
(Bench parameters: TICK_DIV=4, STABLE_TICKS=3, SYNC_STAGES=2.)
- Reset, hold sw_raw=3'b000 for 50 cycles -> W=X=Y=0; changed never pulses; tick pulses every 4th cycle.
- After reset, set sw_raw=3'b100 and hold -> W rises exactly on the 3rd tick after sync[2] goes high; changed pulses once in that cycle; X=Y=0 throughout.
- Drive sw_raw[1] high for 6 cycles, then low (shorter than 3 ticks) -> X stays 0; changed stays 0.
- Set sw_raw 3'b000->3'b011 on one edge and hold -> X and Y rise on the same cycle; exactly one changed pulse.
- Hold sw_raw=3'b111 until W=X=Y=1; pulse rst_n low for 1 cycle mid-count, with sw_raw still 3'b111 -> outputs drop to 0 asynchronously, then re-rise after the full debounce latency.
- With SWITCH_EDGE_EN defined, toggle sw_raw[0] 0->1->0 with stable holds -> rise=3'b001 pulses once, later fall=3'b001 pulses once, each coincident with changed.
